// File: rtl/rc_add_sub_pipe_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// default widths, ALU add/sub encoding and the full-adder cell.
package rc_add_sub_pipe_pkg;

  localparam int unsigned DATA_WIDTH   = 64;
  localparam int unsigned ADDSUB_SLICE = 16;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } addsub_op_e;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/rc_add_sub_pipe_if.sv
// Streaming operand/result interface of the add/sub pipe.
interface rc_add_sub_pipe_if
  import rc_add_sub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
);

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SnA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             OVF;

  modport master (
    output IN_VALID, A, B, SnA, OUT_READY,
    input  IN_READY, OUT_VALID, Y, CO, OVF
  );

  modport slave (
    input  IN_VALID, A, B, SnA, OUT_READY,
    output IN_READY, OUT_VALID, Y, CO, OVF
  );

endinterface

// File: rtl/rc_add_sub_pipe_slice.sv
// SLICE-bit combinational ripple of full-adder cells with B conditionally
// inverted for subtract; also exposes the carry into the slice MSB.
module rc_add_sub_pipe_slice
  import rc_add_sub_pipe_pkg::*;
#(
  parameter int unsigned SLICE = ADDSUB_SLICE
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             sna_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  always_comb begin : ripple
    logic       c;
    logic [1:0] fa;
    c      = cin_i;
    fa     = '0;
    sum_o  = '0;
    cmsb_o = 1'b0;
    for (int unsigned i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) cmsb_o = c;
      fa       = full_add(a_i[i], b_i[i] ^ sna_i, c);
      sum_o[i] = fa[0];
      c        = fa[1];
    end
    cout_o = c;
  end

endmodule

// File: rtl/rc_add_sub_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-bit ripple per stage,
// carry registered between stages, whole pipe advances or stalls together.
module rc_add_sub_pipe
  import rc_add_sub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned SLICE = ADDSUB_SLICE
) (
  input  logic              CLK,
  input  logic              RST,
  rc_add_sub_pipe_if.slave  bus
);

  localparam int unsigned NSTG = WIDTH / SLICE;

  // Registered state of each stage; stage k holds the result of slice k.
  logic [NSTG-1:0]            v_q;
  logic [NSTG-1:0]            sna_q;
  logic [NSTG-1:0]            c_q;
  logic [NSTG-1:0]            cmsb_q;
  logic [NSTG-1:0][WIDTH-1:0] a_q;
  logic [NSTG-1:0][WIDTH-1:0] b_q;
  logic [NSTG-1:0][WIDTH-1:0] y_q;

  // Stage inputs: stage 0 from the bus, later stages from the previous register.
  logic [NSTG-1:0]            v_in;
  logic [NSTG-1:0]            sna_in;
  logic [NSTG-1:0]            c_in;
  logic [NSTG-1:0][WIDTH-1:0] a_in;
  logic [NSTG-1:0][WIDTH-1:0] b_in;
  logic [NSTG-1:0][WIDTH-1:0] y_in;
  logic [NSTG-1:0][WIDTH-1:0] y_d;

  logic [NSTG-1:0][SLICE-1:0] sum;
  logic [NSTG-1:0]            cout;
  logic [NSTG-1:0]            cmsb;

  logic adv;

  assign adv          = ~bus.OUT_VALID | bus.OUT_READY;
  assign bus.IN_READY = adv;

  always_comb begin
    v_in      = '0;
    sna_in    = '0;
    c_in      = '0;
    a_in      = '0;
    b_in      = '0;
    y_in      = '0;
    v_in[0]   = bus.IN_VALID;
    sna_in[0] = bus.SnA;
    c_in[0]   = bus.SnA;
    a_in[0]   = bus.A;
    b_in[0]   = bus.B;
    for (int unsigned k = 1; k < NSTG; k++) begin
      v_in[k]   = v_q[k-1];
      sna_in[k] = sna_q[k-1];
      c_in[k]   = c_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      y_in[k]   = y_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    rc_add_sub_pipe_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a_i    (a_in[k][k*SLICE +: SLICE]),
      .b_i    (b_in[k][k*SLICE +: SLICE]),
      .sna_i  (sna_in[k]),
      .cin_i  (c_in[k]),
      .sum_o  (sum[k]),
      .cout_o (cout[k]),
      .cmsb_o (cmsb[k])
    );
  end

  // Result bits below the current slice ride along; the current slice is merged in.
  always_comb begin
    y_d = y_in;
    for (int unsigned k = 0; k < NSTG; k++) begin
      y_d[k][k*SLICE +: SLICE] = sum[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q    <= '0;
      sna_q  <= '0;
      c_q    <= '0;
      cmsb_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
    end else if (adv) begin
      v_q    <= v_in;
      sna_q  <= sna_in;
      c_q    <= cout;
      cmsb_q <= cmsb;
      a_q    <= a_in;
      b_q    <= b_in;
      y_q    <= y_d;
    end
  end

  assign bus.OUT_VALID = v_q[NSTG-1];
  assign bus.Y         = y_q[NSTG-1];
  assign bus.CO        = c_q[NSTG-1];
  assign bus.OVF       = cmsb_q[NSTG-1] ^ c_q[NSTG-1];

  // Already-consumed operand slices and intermediate MSB carries are dead bits.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, sna_q, cmsb_q};

endmodule
